// File: rtl/ama_riscv_reg_file_writer_pkg.sv
// Shared register-file parameters and writer state encoding.
// Imported by the writer interface, the writer and its bench.
package ama_riscv_reg_file_writer_pkg;

    localparam int REG_NUM        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int DROP_WIDTH     = 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [DROP_WIDTH-1:0]     drop_cnt_t;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/ama_riscv_reg_file_writer_if.sv
// Request side and register-file write side of the writer.
// master drives requests; slave is the writer itself.
interface ama_riscv_reg_file_writer_if;
    import ama_riscv_reg_file_writer_pkg::*;

    logic      req_valid;
    reg_addr_t req_addr;
    reg_data_t req_data;
    logic      clear_req;
    logic      req_ready;
    logic      we;
    reg_addr_t addr_d;
    reg_data_t data_d;
    logic      init_done;
    drop_cnt_t drop_cnt;

    modport master (
        output req_valid, req_addr, req_data, clear_req,
        input  req_ready, we, addr_d, data_d, init_done, drop_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_data, clear_req,
        output req_ready, we, addr_d, data_d, init_done, drop_cnt
    );

endinterface

// File: rtl/ama_riscv_reg_file_writer.sv
// Register-file writer: zeroes x1-x31 after reset or on request,
// then forwards accepted write requests, dropping writes to x0.
module ama_riscv_reg_file_writer
    import ama_riscv_reg_file_writer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    ama_riscv_reg_file_writer_if.slave   bus
);

    logic [0:0] r_state;
    reg_addr_t  r_clr_cnt;
    logic       r_we;
    reg_addr_t  r_addr_d;
    reg_data_t  r_data_d;
    logic       r_init_done;
    drop_cnt_t  r_drop_cnt;

    logic       w_ready;

    assign w_ready       = (r_state == ST_RUN) && !bus.clear_req;
    assign bus.req_ready = w_ready;
    assign bus.we        = r_we;
    assign bus.addr_d    = r_addr_d;
    assign bus.data_d    = r_data_d;
    assign bus.init_done = r_init_done;
    assign bus.drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= reg_addr_t'(1);
            r_we        <= 1'b0;
            r_addr_d    <= '0;
            r_data_d    <= '0;
            r_init_done <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    // counter wraps to 0 only after x31 was written
                    if (r_clr_cnt == '0) begin
                        r_init_done <= 1'b1;
                        r_state     <= ST_RUN;
                        r_clr_cnt   <= reg_addr_t'(1);
                    end else begin
                        r_we      <= 1'b1;
                        r_addr_d  <= r_clr_cnt;
                        r_data_d  <= '0;
                        r_clr_cnt <= r_clr_cnt + reg_addr_t'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.clear_req) begin
                        r_state     <= ST_CLEAR;
                        r_init_done <= 1'b0;
                        r_clr_cnt   <= reg_addr_t'(1);
                    end else if (bus.req_valid) begin
                        if (bus.req_addr == '0) begin
                            r_drop_cnt <= sat_inc(r_drop_cnt);
                        end else begin
                            r_we     <= 1'b1;
                            r_addr_d <= bus.req_addr;
                            r_data_d <= bus.req_data;
                        end
                    end
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ama_riscv_reg_file_writer.sv
// Bench for the register-file writer: vector table, directed
// sequences and random traffic against an edge-count model.
module tb_ama_riscv_reg_file_writer;
    import ama_riscv_reg_file_writer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    ama_riscv_reg_file_writer_if bus ();

    ama_riscv_reg_file_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // model: m_t counts edges since the clear started; 32+ means running
    int          m_t;
    bit          m_init;
    int          m_drop;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_rf [32];
    logic [31:0] dut_rf [32];

    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
        bit          ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_t = 0; m_init = 0; m_drop = 0;
        m_we = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step(input bit v, input logic [4:0] a,
                              input logic [31:0] d, input bit c);
        m_we = 0;
        if (m_t < 32) begin
            m_t++;
            if (m_t <= 31) begin
                m_we = 1; m_addr = 5'(m_t); m_data = 0;
            end else m_init = 1;
        end else if (c) begin
            m_t = 0; m_init = 0;
        end else if (v) begin
            if (a == 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else begin
                m_we = 1; m_addr = a; m_data = d;
            end
        end
        if (m_we) m_rf[m_addr] = m_data;
    endtask

    task automatic cmp_outputs();
        chk("we", 32'(bus.we), 32'(m_we));
        chk("addr_d", 32'(bus.addr_d), 32'(m_addr));
        chk("data_d", bus.data_d, m_data);
        chk("init_done", 32'(bus.init_done), 32'(m_init));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        if (bus.we) chk("we_addr_nonzero", 32'(bus.addr_d != 0), 1);
    endtask

    task automatic cyc(input bit v, input logic [4:0] a,
                       input logic [31:0] d, input bit c);
        bus.req_valid = v; bus.req_addr = a;
        bus.req_data = d;  bus.clear_req = c;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(m_t >= 32 && !c));
        @(posedge clk); #1;
        model_step(v, a, d, c);
        cmp_outputs();
        if (bus.we) dut_rf[bus.addr_d] = bus.data_d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0);
    endtask

    function automatic logic [31:0] rd(input int i);
        return (i == 0) ? 32'd0 : dut_rf[i];
    endfunction

    task automatic rf_check(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_portA"}, rd(i), (i == 0) ? 32'd0 : m_rf[i]);
            chk({tag, "_portB"}, rd(31 - i),
                (i == 31) ? 32'd0 : m_rf[31 - i]);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = 0; bus.req_addr = '0;
        bus.req_data = '0; bus.clear_req = 0;
        rst = 1;
        #1;
        model_reset();
        cmp_outputs();
        chk("rst_ready", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        cmp_outputs();
        for (int i = 0; i < 32; i++) begin
            dut_rf[i] = (i == 0) ? 32'd0 : $urandom;
            m_rf[i] = dut_rf[i];
        end
        rst = 0;
    endtask

    initial begin
        tbl[0] = '{1, 5'd3,  32'h0000_0011, 1, 5'd3,  32'h0000_0011};
        tbl[1] = '{1, 5'd0,  32'hDEAD_BEEF, 0, 5'd3,  32'h0000_0011};
        tbl[2] = '{0, 5'd9,  32'h0000_0022, 0, 5'd3,  32'h0000_0011};
        tbl[3] = '{1, 5'd31, 32'hFFFF_FFFF, 1, 5'd31, 32'hFFFF_FFFF};
        tbl[4] = '{1, 5'd1,  32'h0000_0001, 1, 5'd1,  32'h0000_0001};
        tbl[5] = '{0, 5'd0,  32'h0000_0000, 0, 5'd1,  32'h0000_0001};

        // reset and initial clear of a randomly prefilled file
        do_reset();
        idle(31);
        chk("init_before_32", 32'(bus.init_done), 0);
        idle(1);
        chk("init_at_32", 32'(bus.init_done), 1);
        rf_check("clear0");

        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].v, tbl[i].a, tbl[i].d, 0);
            chk("tbl_we", 32'(bus.we), 32'(tbl[i].ewe));
            chk("tbl_addr", 32'(bus.addr_d), 32'(tbl[i].ea));
            chk("tbl_data", bus.data_d, tbl[i].ed);
        end

        // 31 back-to-back writes
        for (int i = 1; i < 32; i++) begin
            cyc(1, 5'(i), $urandom, 0);
            chk("b2b_no_bubble", 32'(bus.we), 1);
        end
        idle(1);
        rf_check("b2b");

        // x0 drops and saturation
        begin
            int d0;
            d0 = int'(bus.drop_cnt);
            cyc(1, 5'd0, 32'hDEAD_BEEF, 0);
            chk("x0_we", 32'(bus.we), 0);
            chk("drop_plus1", 32'(bus.drop_cnt), 32'(d0 + 1));
            chk("x0_read", rd(0), 0);
        end
        for (int i = 0; i < 300; i++) cyc(1, 5'd0, 32'hDEAD_BEEF, 0);
        chk("drop_sat", 32'(bus.drop_cnt), 255);

        // clear request while x5 holds data; extra clear cycles ignored
        cyc(1, 5'd5, 32'h1234, 0);
        idle(1);
        chk("x5_set", rd(5), 32'h1234);
        cyc(0, 5'd0, 32'd0, 1);
        chk("clr_init_low", 32'(bus.init_done), 0);
        cyc(0, 5'd0, 32'd0, 1);
        cyc(0, 5'd0, 32'd0, 1);
        chk("clr_not_restarted", 32'(bus.addr_d), 2);
        idle(29);
        chk("clr_x5_zero", rd(5), 0);
        chk("clr_init_still_low", 32'(bus.init_done), 0);
        idle(1);
        chk("clr_init_high", 32'(bus.init_done), 1);

        // accept right before clear: write lands first, then zeroed
        cyc(1, 5'd7, 32'hA5A5_A5A5, 0);
        cyc(0, 5'd0, 32'd0, 1);
        chk("pre_clr_write", 32'(bus.addr_d), 7);
        chk("pre_clr_data", bus.data_d, 32'hA5A5_A5A5);
        idle(1);
        chk("first_clear_addr", 32'(bus.addr_d), 1);
        idle(31);
        chk("x7_zero", rd(7), 0);
        rf_check("clear7");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cyc(1'($urandom_range(0, 1)), a, $urandom,
                $urandom_range(0, 59) == 0);
        end
        idle(33);
        rf_check("rand");

        // reset in the middle of a clear
        do_reset();
        idle(15);
        chk("pre_rst_addr15", 32'(bus.addr_d), 15);
        do_reset();
        idle(1);
        chk("restart_addr", 32'(bus.addr_d), 1);
        chk("restart_we", 32'(bus.we), 1);
        idle(31);
        rf_check("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
